// File: rtl/adc366x_dly_cal.sv
// IDELAY tap calibration for the ADC366x LVDS receiver: sweep, map, find widest eye, load centre.
// Optional macro ADC_DLY_MAP_EN exposes the stored per-lane pass map via map_sel_i/map_o.
module adc366x_dly_cal #(
  parameter int LANES   = 5,
  parameter int TAP_W   = 5,
  parameter int SETTLE  = 16,
  parameter int CHECK   = 256,
  parameter int MIN_EYE = 4
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     en_i,
  input  logic                     start_i,
  input  logic [LANES-1:0]         lane_ok_i,
  output logic [LANES*TAP_W:0]     dly_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [LANES-1:0]         lock_o,
  output logic [LANES*6-1:0]       eye_o
`ifdef ADC_DLY_MAP_EN
  ,
  input  logic [2:0]               map_sel_i,
  output logic [31:0]              map_o
`endif
);

  localparam int NTAP = 1 << TAP_W;
  localparam int EW   = TAP_W + 1;
  localparam int CW   = $clog2((CHECK > SETTLE ? CHECK : SETTLE) + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_EVAL, S_APPLY, S_DONE
  } state_t;

  state_t                   r_state;
  logic [CW-1:0]            r_cnt;
  logic [TAP_W-1:0]         r_tap;
  logic [LANES-1:0]         r_ok;
  logic [NTAP-1:0]          r_map [LANES];
  logic [2:0]               r_lane;
  logic [TAP_W-1:0]         r_bit;
  logic [EW-1:0]            r_run_len;
  logic [TAP_W-1:0]         r_run_start;
  logic [EW-1:0]            r_best_len;
  logic [TAP_W-1:0]         r_best_start;
  logic [LANES*TAP_W-1:0]   r_res_tap;
  logic [LANES-1:0]         r_res_lock;
  logic [LANES*EW-1:0]      r_res_eye;
  logic [LANES*TAP_W-1:0]   r_taps;
  logic                     r_stb;
  logic                     r_busy;
  logic                     r_done;
  logic [LANES-1:0]         r_lock;
  logic [LANES*EW-1:0]      r_eye;
  logic                     r_zpend;
  logic [2:0]               r_zcnt;

  logic                     w_bit;
  logic [EW-1:0]            w_prev_run;
  logic [EW-1:0]            w_prev_best;
  logic [TAP_W-1:0]         w_prev_bstart;
  logic [EW-1:0]            w_cur_len;
  logic [TAP_W-1:0]         w_cur_start;
  logic [EW-1:0]            w_best_len;
  logic [TAP_W-1:0]         w_best_start;
  logic [TAP_W:0]           w_sum;
  logic [TAP_W-1:0]         w_centre;
  logic                     w_lock;
  logic [TAP_W-1:0]         w_res_tap;
  logic [TAP_W-1:0]         w_tap_inc;
  logic [LANES-1:0]         w_pass;
  logic [LANES*TAP_W-1:0]   w_apply_taps;

  // Run tracking restarts at bit 0 of each lane, so runs never wrap between lanes or bit 31/0.
  always_comb begin
    w_bit         = r_map[r_lane][r_bit];
    w_prev_run    = (r_bit == '0) ? '0 : r_run_len;
    w_prev_best   = (r_bit == '0) ? '0 : r_best_len;
    w_prev_bstart = (r_bit == '0) ? '0 : r_best_start;
    w_cur_len     = w_bit ? (w_prev_run + 1'b1) : '0;
    w_cur_start   = (w_bit && (w_prev_run == '0)) ? r_bit : r_run_start;
    if (w_cur_len > w_prev_best) begin
      w_best_len   = w_cur_len;
      w_best_start = w_cur_start;
    end else begin
      w_best_len   = w_prev_best;
      w_best_start = w_prev_bstart;
    end
    w_sum     = {1'b0, w_best_start} + {1'b0, w_best_len[TAP_W:1]};
    w_centre  = w_sum[TAP_W] ? {TAP_W{1'b1}} : w_sum[TAP_W-1:0];
    w_lock    = (w_best_len >= EW'(MIN_EYE));
    w_res_tap = w_lock ? w_centre : '0;
    w_tap_inc = r_tap + 1'b1;
    w_pass    = r_ok & lane_ok_i;
  end

  // The last lane's result is still combinational when APPLY is entered.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_apply
      assign w_apply_taps[gi*TAP_W +: TAP_W] =
        (r_lane == 3'(gi)) ? w_res_tap : r_res_tap[gi*TAP_W +: TAP_W];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_tap        <= '0;
      r_ok         <= '0;
      for (int l = 0; l < LANES; l++) r_map[l] <= '0;
      r_lane       <= '0;
      r_bit        <= '0;
      r_run_len    <= '0;
      r_run_start  <= '0;
      r_best_len   <= '0;
      r_best_start <= '0;
      r_res_tap    <= '0;
      r_res_lock   <= '0;
      r_res_eye    <= '0;
      r_taps       <= '0;
      r_stb        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_lock       <= '0;
      r_eye        <= '0;
      r_zpend      <= 1'b0;
      r_zcnt       <= '0;
    end else begin
      r_done <= 1'b0;
      if (!en_i && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_taps  <= '0;
        r_stb   <= 1'b0;
        r_busy  <= 1'b0;
        r_lock  <= '0;
        r_eye   <= '0;
        r_zpend <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            // A pending zero-tap strobe finishes before a new sweep may change the taps.
            if (r_zpend) begin
              r_zpend <= 1'b0;
              r_stb   <= 1'b1;
              r_zcnt  <= 3'd4;
            end else if (r_zcnt != '0) begin
              r_zcnt <= r_zcnt - 1'b1;
              if (r_zcnt == 3'd1) r_stb <= 1'b0;
            end else if (start_i && en_i) begin
              r_state <= S_LOAD;
              r_tap   <= '0;
              r_taps  <= '0;
              r_stb   <= 1'b1;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_lock  <= '0;
              r_eye   <= '0;
              for (int l = 0; l < LANES; l++) r_map[l] <= '0;
            end
          end
          S_LOAD, S_APPLY: begin
            if (r_cnt == CW'(3)) begin
              r_stb   <= 1'b0;
              r_cnt   <= '0;
              r_state <= (r_state == S_LOAD) ? S_SETTLE : S_DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_SETTLE: begin
            if (r_cnt == CW'(SETTLE - 1)) begin
              r_cnt   <= '0;
              r_ok    <= '1;
              r_state <= S_CHECK;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_CHECK: begin
            r_ok <= w_pass;
            if (r_cnt == CW'(CHECK - 1)) begin
              for (int l = 0; l < LANES; l++) r_map[l][r_tap] <= w_pass[l];
              r_cnt <= '0;
              if (r_tap == TAP_W'(NTAP - 1)) begin
                r_state <= S_EVAL;
                r_lane  <= '0;
                r_bit   <= '0;
              end else begin
                r_tap   <= w_tap_inc;
                r_taps  <= {LANES{w_tap_inc}};
                r_stb   <= 1'b1;
                r_state <= S_LOAD;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_EVAL: begin
            r_run_len    <= w_cur_len;
            r_run_start  <= w_cur_start;
            r_best_len   <= w_best_len;
            r_best_start <= w_best_start;
            r_bit        <= r_bit + 1'b1;
            if (r_bit == TAP_W'(NTAP - 1)) begin
              r_res_tap[r_lane*TAP_W +: TAP_W] <= w_res_tap;
              r_res_lock[r_lane]               <= w_lock;
              r_res_eye[r_lane*EW +: EW]       <= w_best_len;
              if (r_lane == 3'(LANES - 1)) begin
                r_taps  <= w_apply_taps;
                r_stb   <= 1'b1;
                r_cnt   <= '0;
                r_state <= S_APPLY;
              end else begin
                r_lane <= r_lane + 1'b1;
              end
            end
          end
          S_DONE: begin
            r_done  <= 1'b1;
            r_lock  <= r_res_lock;
            r_eye   <= r_res_eye;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef ADC_DLY_MAP_EN
  logic [31:0] r_map_o;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_map_o <= '0;
    else         r_map_o <= (map_sel_i < 3'(LANES)) ? 32'(r_map[map_sel_i]) : '0;
  end
  assign map_o = r_map_o;
`endif

  assign dly_o  = {r_stb, r_taps};
  assign busy_o = r_busy;
  assign done_o = r_done;
  assign lock_o = r_lock;
  assign eye_o  = r_eye;

endmodule

// File: tb/tb_adc366x_dly_cal.sv
// Scoreboard bench for adc366x_dly_cal: receiver model latches taps on the strobe and answers lane_ok.
module tb_adc366x_dly_cal;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        en_i = 1'b1;
  logic        start_i = 1'b0;
  logic [4:0]  lane_ok_i = '0;
  logic [25:0] dly_o;
  logic        busy_o, done_o;
  logic [4:0]  lock_o;
  logic [29:0] eye_o;
`ifdef ADC_DLY_MAP_EN
  logic [2:0]  map_sel_i = '0;
  logic [31:0] map_o;
`endif

  adc366x_dly_cal dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .en_i(en_i), .start_i(start_i),
    .lane_ok_i(lane_ok_i), .dly_o(dly_o), .busy_o(busy_o), .done_o(done_o),
    .lock_o(lock_o), .eye_o(eye_o)
`ifdef ADC_DLY_MAP_EN
    , .map_sel_i(map_sel_i), .map_o(map_o)
`endif
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct {
    int          id;
    int          t0;
    logic [24:0] taps;
    logic [4:0]  lock;
    logic [29:0] eye;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_strobe = 0;
  logic [31:0] pass_mask [5];
  bit          glitch_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  initial forever @(posedge clk_i) cyc++;

  // Receiver model: taps latch while the strobe is high; lane_ok follows the latched tap.
  initial begin : rx_model
    logic [4:0] rx_tap [5];
    int since_load;
    since_load = 0;
    for (int l = 0; l < 5; l++) rx_tap[l] = '0;
    forever begin
      @(negedge clk_i);
      if (dly_o[25]) begin
        for (int l = 0; l < 5; l++) rx_tap[l] = dly_o[l*5 +: 5];
        since_load = 0;
      end else begin
        since_load++;
      end
      for (int l = 0; l < 5; l++)
        lane_ok_i[l] = pass_mask[l][rx_tap[l]] &&
                       !(glitch_en && l == 1 && rx_tap[l] == 5'd7 && since_load == 120);
    end
  end

  // Strobe watcher: every strobe lasts 4 cycles with constant taps.
  initial begin : strobe_mon
    int run;
    logic [24:0] held;
    bit moved;
    run = 0; held = '0; moved = 0;
    forever begin
      @(negedge clk_i);
      if (!rstn_i) begin
        run = 0;
      end else if (dly_o[25]) begin
        if (run == 0) begin held = dly_o[24:0]; moved = 0; end
        else if (dly_o[24:0] !== held) moved = 1;
        run++;
      end else if (run != 0) begin
        chk("strobe_len", 64'(run), 64'd4);
        chk("strobe_taps_stable", 64'(moved), 64'd0);
        n_strobe++;
        run = 0;
      end
    end
  end

  // Monitor: each done_o pulse pops one expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (done_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("latency", 64'(cyc - e.t0), 64'd8998);
          chk("taps", 64'(dly_o[24:0]), 64'(e.taps));
          chk("lock", 64'(lock_o), 64'(e.lock));
          chk("eye", 64'(eye_o), 64'(e.eye));
          $display("txn %0d: latency=%0d taps=%h lock=%b eye=%h", e.id, cyc - e.t0,
                   dly_o[24:0], lock_o, eye_o);
        end
      end
    end
  end

  task automatic all_pass();
    for (int l = 0; l < 5; l++) pass_mask[l] = 32'hFFFF_FFFF;
    glitch_en = 0;
  endtask

  task automatic run_cal(input int id, input logic [24:0] taps, input logic [4:0] lock,
                         input logic [29:0] eye, input int repulse);
    exp_t e;
    @(negedge clk_i);
    e.id = id; e.t0 = cyc; e.taps = taps; e.lock = lock; e.eye = eye;
    sb.push_back(e);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < 12000 && sb.size() != 0; i++) begin
      @(negedge clk_i);
      start_i = (i == repulse);
    end
    start_i = 1'b0;
    if (sb.size() != 0) begin
      chk("done_timeout", 64'd1, 64'd0);
      sb.delete();
    end
    repeat (8) @(negedge clk_i);
  endtask

  localparam logic [24:0] T16 = {5'd16, 5'd16, 5'd16, 5'd16, 5'd16};
  localparam logic [29:0] E32 = {6'd32, 6'd32, 6'd32, 6'd32, 6'd32};

  initial begin
    int t0;
    int s0;
    bit seen;
    all_pass();
    repeat (3) @(negedge clk_i);
    chk("rst_dly", 64'(dly_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_lock", 64'(lock_o), 64'd0);
    chk("rst_eye", 64'(eye_o), 64'd0);
    rstn_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // All taps pass, start re-pulsed mid-sweep must be ignored.
    run_cal(1, T16, 5'h1F, E32, 3000);

    pass_mask[0] = 32'h000F_FC00;
    run_cal(2, {5'd16, 5'd16, 5'd16, 5'd16, 5'd15}, 5'h1F,
            {6'd32, 6'd32, 6'd32, 6'd32, 6'd10}, -1);

    all_pass();
    pass_mask[2] = 32'h0070_0038;
    run_cal(3, {5'd16, 5'd16, 5'd0, 5'd16, 5'd16}, 5'b11011,
            {6'd32, 6'd32, 6'd3, 6'd32, 6'd32}, -1);

    pass_mask[2] = 32'h03F0_0038;
    run_cal(4, {5'd16, 5'd16, 5'd23, 5'd16, 5'd16}, 5'h1F,
            {6'd32, 6'd32, 6'd6, 6'd32, 6'd32}, -1);

    all_pass();
    glitch_en = 1;
    run_cal(5, {5'd16, 5'd16, 5'd16, 5'd20, 5'd16}, 5'h1F,
            {6'd32, 6'd32, 6'd32, 6'd24, 6'd32}, -1);

    // Abort during tap 12 CHECK.
    all_pass();
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 6000 && !seen; i++) begin
      @(negedge clk_i);
      seen = (dly_o[4:0] == 5'd12) && !dly_o[25] && busy_o;
    end
    chk("abort_reach_tap12", 64'(seen), 64'd1);
    repeat (50) @(negedge clk_i);
    s0 = n_strobe;
    en_i = 1'b0;
    @(negedge clk_i);
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_dly", 64'(dly_o), 64'd0);
    @(negedge clk_i);
    chk("abort_zero_strobe", 64'(dly_o), 64'h200_0000);
    repeat (10) @(negedge clk_i);
    chk("abort_strobe_count", 64'(n_strobe - s0), 64'd1);
    chk("abort_lock", 64'(lock_o), 64'd0);
    chk("abort_eye", 64'(eye_o), 64'd0);
    en_i = 1'b1;
    repeat (2) @(negedge clk_i);
    run_cal(6, T16, 5'h1F, E32, -1);

    // Asynchronous reset while the APPLY strobe is high.
    @(negedge clk_i);
    start_i = 1'b1;
    t0 = cyc;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < 12000 && cyc < t0 + 8994; i++) @(negedge clk_i);
    chk("apply_strobe_high", 64'({dly_o[25], busy_o}), 64'd3);
    #1 rstn_i = 1'b0;
    #1;
    chk("midapply_rst_dly", 64'(dly_o), 64'd0);
    chk("midapply_rst_busy", 64'(busy_o), 64'd0);
    @(negedge clk_i);
    #1 rstn_i = 1'b1;
    repeat (20) @(negedge clk_i);
    chk("post_rst_lock", 64'(lock_o), 64'd0);
    chk("post_rst_strobe", 64'(dly_o[25]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
